// File: rtl/keypoint_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : keypoint_collector_if
// Description : Keypoint readout port carrying the FIFO head and its
//               valid/ready handshake.
//               master : producer side (drives okp_*, samples iready)
//               slave  : consumer side (samples okp_*, drives iready)
//   okp_valid  head entry present
//   iready     consumer accepts the head this cycle
//   okp_x/y    head coordinates
//   okp_scale  head DoG scale index
// Revision    : 1.0 - initial release
// ============================================================================
interface keypoint_collector_if #(
    parameter int COORD_W = 10
);
    logic               okp_valid;
    logic               iready;
    logic [COORD_W-1:0] okp_x;
    logic [COORD_W-1:0] okp_y;
    logic [1:0]         okp_scale;

    modport master (
        output okp_valid,
        output okp_x,
        output okp_y,
        output okp_scale,
        input  iready
    );

    modport slave (
        input  okp_valid,
        input  okp_x,
        input  okp_y,
        input  okp_scale,
        output iready
    );
endinterface
`default_nettype wire

// File: rtl/keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module      : keypoint_collector
// Description : Re-aligns SIFT candidates with their late low-contrast/edge
//               reject flags, buffers survivors in a first-word-fall-through
//               FIFO drained over a valid/ready port, and counts accepted and
//               dropped keypoints per frame.
//   iclk, irst                  clock, synchronous active-high reset
//   iframe_start, iframe_end    frame delimiting pulses
//   ivalid, icandidate, ix, iy, iscale   candidate stream
//   ilowcontrast_en, iedge_en   reject flags, FLAG_LAT cycles late
//   kp                          keypoint readout port (master)
//   okp_count, odrop_count      per-frame accepted / dropped counts
//   ofifo_full                  FIFO holds DEPTH entries
//   oframe_done                 one-cycle pulse at frame completion
// Revision    : 1.0 - initial release
// ============================================================================
module keypoint_collector #(
    parameter int COORD_W  = 10,
    parameter int DEPTH    = 16,
    parameter int FLAG_LAT = 1
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               iframe_start,
    input  logic               iframe_end,
    input  logic               ivalid,
    input  logic               icandidate,
    input  logic [COORD_W-1:0] ix,
    input  logic [COORD_W-1:0] iy,
    input  logic [1:0]         iscale,
    input  logic               ilowcontrast_en,
    input  logic               iedge_en,
    keypoint_collector_if.master kp,
    output logic [15:0]        okp_count,
    output logic [15:0]        odrop_count,
    output logic               ofifo_full,
    output logic               oframe_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(FLAG_LAT + 1);
    localparam int EW = 2 * COORD_W + 2;    // stored entry {x, y, scale}
    localparam int DW = EW + 2;             // delay entry {valid, cand, x, y, scale}

    localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0] c_lat   = LW'(FLAG_LAT);
    localparam logic [15:0]   c_sat   = 16'hFFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state, w_state_nxt;
    logic [LW-1:0] r_drain_cnt, w_drain_nxt;

    logic [DW-1:0] r_dly [FLAG_LAT];
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_occ, w_occ_nxt;
    logic          r_valid, r_full;
    logic [15:0]   r_kp_cnt, r_drop_cnt;

    logic          w_d_valid, w_d_cand, w_active, w_keep, w_pop, w_push, w_drop;
    logic [EW-1:0] w_d_entry, w_head;

    // Candidate delay line; its last stage lines up with the reject flags.
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < FLAG_LAT; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= {ivalid, icandidate, ix, iy, iscale};
            for (int i = 1; i < FLAG_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_d_valid = r_dly[FLAG_LAT-1][DW-1];
    assign w_d_cand  = r_dly[FLAG_LAT-1][DW-2];
    assign w_d_entry = r_dly[FLAG_LAT-1][EW-1:0];

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_keep   = w_active & w_d_valid & w_d_cand & ~ilowcontrast_en & ~iedge_en;
    assign w_pop    = r_valid & kp.iready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push   = w_keep & ((r_occ != c_depth) | w_pop);
    assign w_drop   = w_keep & ~w_push;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 1'b1;
            2'b01:   w_occ_nxt = r_occ - 1'b1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != '0);
            r_full  <= (w_occ_nxt == c_depth);
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge iclk) begin
        if (w_push) r_mem[r_wptr] <= w_d_entry;
    end

    // Head is read combinationally (fall-through) and zeroed while empty.
    assign w_head       = r_valid ? r_mem[r_rptr] : '0;
    assign kp.okp_valid = r_valid;
    assign kp.okp_x     = w_head[EW-1 -: COORD_W];
    assign kp.okp_y     = w_head[COORD_W+1 -: COORD_W];
    assign kp.okp_scale = w_head[1:0];

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_kp_cnt   <= '0;
            r_drop_cnt <= '0;
        end else if ((r_state == S_IDLE) && iframe_start) begin
            r_kp_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push && (r_kp_cnt != c_sat))   r_kp_cnt   <= r_kp_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != c_sat)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // DRAIN keeps pushing for FLAG_LAT cycles so candidates still in the delay
    // line are resolved; the last of those cycles is when the count reads 1.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            S_IDLE:  if (iframe_start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (iframe_end) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = c_lat;
                end
            end
            S_DRAIN: begin
                if ((r_drain_cnt <= LW'(1)) && (w_occ_nxt == '0)) begin
                    w_state_nxt = S_DONE;
                    w_drain_nxt = '0;
                end else if (r_drain_cnt != '0) begin
                    w_drain_nxt = r_drain_cnt - 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign okp_count   = r_kp_cnt;
    assign odrop_count = r_drop_cnt;
    assign ofifo_full  = r_full;
    assign oframe_done = (r_state == S_DONE);
endmodule
`default_nettype wire
